// File: rtl/irq_ctrl.sv
// Interrupt controller feeding the 6502 IRQB pin: sync, latch (level/edge), mask, vector; optional NMI routing under IRQ_CTRL_NMI_EN.
// Latency: src_n to irq_n/nmi_n is SYNC_STAGES + 2 edges; register reads return rdata one cycle after rd_en.
// Backpressure: none; single-cycle rd_en/wr_en strobes are always accepted, rdata holds until the next read.
module irq_ctrl #(
    parameter int SOURCES     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [SOURCES-1:0] src_n,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [2:0]         reg_addr,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    output logic               rdata_valid,
    output logic               irq_n,
    output logic               nmi_n
);

    localparam logic [2:0] A_STATUS  = 3'd0;
    localparam logic [2:0] A_PENDING = 3'd1;
    localparam logic [2:0] A_MASK    = 3'd2;
    localparam logic [2:0] A_MODE    = 3'd3;
    localparam logic [2:0] A_VECTOR  = 3'd4;
    localparam logic [2:0] A_NMI_SEL = 3'd5;

    // Register bits at and above SOURCES read as zero.
    function automatic logic [7:0] ext(input logic [SOURCES-1:0] v);
        logic [7:0] r;
        r = '0;
        r[SOURCES-1:0] = v;
        return r;
    endfunction

    logic [SOURCES-1:0] sync_q [SYNC_STAGES];
    logic [SOURCES-1:0] s;
    logic [SOURCES-1:0] prev_q;
    logic [SOURCES-1:0] pending_q, pending_d;
    logic [SOURCES-1:0] mask_q, mask_d;
    logic [SOURCES-1:0] mode_q, mode_d;
    logic [SOURCES-1:0] fall;
    logic [SOURCES-1:0] clr;
    logic [SOURCES-1:0] enabled;
    logic [7:0]         vector;
    logic [7:0]         rd_val;
    logic [7:0]         rdata_q;
    logic               rdata_valid_q;
    logic               irq_n_q;

    assign s       = sync_q[SYNC_STAGES-1];
    assign enabled = pending_q & mask_q;

    // Input synchronisers; idle (high) after reset so no spurious edge is seen.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
        end else begin
            sync_q[0] <= src_n;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Next-state for pending (level follows the line, edge is sticky until W1C; set beats clear), mask and mode.
    always_comb begin
        fall      = prev_q & ~s;
        clr       = (wr_en && reg_addr == A_PENDING) ? wdata[SOURCES-1:0] : '0;
        pending_d = (mode_q & (fall | (pending_q & ~clr))) | (~mode_q & ~s);
        mask_d    = mask_q;
        mode_d    = mode_q;
        if (wr_en && reg_addr == A_MASK) mask_d = wdata[SOURCES-1:0];
        if (wr_en && reg_addr == A_MODE) mode_d = wdata[SOURCES-1:0];
    end

    // Lowest-numbered enabled pending source wins the vector; 0x80 flags none.
    always_comb begin
        vector = 8'h80;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            if (enabled[i]) vector = {5'b0, 3'(i)};
        end
    end

`ifdef IRQ_CTRL_NMI_EN
    logic [SOURCES-1:0] nmi_sel_q, nmi_sel_d;
    logic               nmi_n_q;

    // NMI select register; NMI routing ignores MASK.
    always_comb begin
        nmi_sel_d = nmi_sel_q;
        if (wr_en && reg_addr == A_NMI_SEL) nmi_sel_d = wdata[SOURCES-1:0];
    end

    // NMI select and registered NMI request.
    always_ff @(posedge clock) begin
        if (reset) begin
            nmi_sel_q <= '0;
            nmi_n_q   <= 1'b1;
        end else begin
            nmi_sel_q <= nmi_sel_d;
            nmi_n_q   <= ~|(pending_q & nmi_sel_q);
        end
    end

    assign nmi_n = nmi_n_q;
`else
    assign nmi_n = 1'b1;
`endif

    // Read mux over the current registered state (a same-cycle write is not yet visible).
    always_comb begin
        rd_val = 8'h00;
        case (reg_addr)
            A_STATUS:  rd_val = ext(~s);
            A_PENDING: rd_val = ext(pending_q);
            A_MASK:    rd_val = ext(mask_q);
            A_MODE:    rd_val = ext(mode_q);
            A_VECTOR:  rd_val = vector;
`ifdef IRQ_CTRL_NMI_EN
            A_NMI_SEL: rd_val = ext(nmi_sel_q);
`endif
            default:   rd_val = 8'h00;
        endcase
    end

    // Interrupt state, registered request and read-data registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q        <= '1;
            pending_q     <= '0;
            mask_q        <= '0;
            mode_q        <= '0;
            irq_n_q       <= 1'b1;
            rdata_q       <= 8'h00;
            rdata_valid_q <= 1'b0;
        end else begin
            prev_q        <= s;
            pending_q     <= pending_d;
            mask_q        <= mask_d;
            mode_q        <= mode_d;
            irq_n_q       <= ~|enabled;
            rdata_valid_q <= rd_en;
            if (rd_en) rdata_q <= rd_val;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign irq_n       = irq_n_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: read data is scoreboarded through a queue, request pins checked at fixed edges.
module tb_irq_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] src_n;
    logic       wr_en;
    logic       rd_en;
    logic [2:0] reg_addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       irq_n;
    logic       nmi_n;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb [$];

    irq_ctrl #(.SOURCES(8), .SYNC_STAGES(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .src_n       (src_n),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .reg_addr    (reg_addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .irq_n       (irq_n),
        .nmi_n       (nmi_n)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        wr_en    = 1'b1;
        reg_addr = a;
        wdata    = d;
        tick();
        wr_en    = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
        logic [7:0] e;
        rd_en    = 1'b1;
        reg_addr = a;
        sb.push_back(exp);
        tick();
        rd_en    = 1'b0;
        check({tag, "_valid"}, rdata_valid, 1);
        e = sb.pop_front();
        check(tag, rdata, e);
        tick();
        check({tag, "_valid_drop"}, rdata_valid, 0);
        check({tag, "_hold"}, rdata, e);
    endtask

    initial begin
        reset    = 1'b1;
        src_n    = 8'hFF;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        reg_addr = 3'd0;
        wdata    = 8'h00;
        ticks(3);
        check("rst_irq_n", irq_n, 1);
        check("rst_nmi_n", nmi_n, 1);
        check("rst_rdata", rdata, 8'h00);
        check("rst_rvalid", rdata_valid, 0);
        reset = 1'b0;
        tick();

        // Reset values of the register window.
        rd(3'd0, 8'h00, "rst_status");
        rd(3'd1, 8'h00, "rst_pending");
        rd(3'd2, 8'h00, "rst_mask");
        rd(3'd3, 8'h00, "rst_mode");
        rd(3'd4, 8'h80, "rst_vector");
        rd(3'd5, 8'h00, "rst_nmisel");
        rd(3'd6, 8'h00, "rst_unlisted");

        // Level source 0: 4-edge assertion latency, W1C ignored while held low.
        wr(3'd2, 8'h01);
        src_n = 8'hFE;
        ticks(3);
        check("lvl_irq_k2", irq_n, 1);
        tick();
        check("lvl_irq_k3", irq_n, 0);
        rd(3'd4, 8'h00, "lvl_vector");
        rd(3'd0, 8'h01, "lvl_status");
        wr(3'd1, 8'h01);
        rd(3'd1, 8'h01, "lvl_w1c_ignored");
        check("lvl_irq_held", irq_n, 0);
        src_n = 8'hFF;
        ticks(3);
        check("lvl_rel_k2", irq_n, 0);
        tick();
        check("lvl_rel_k3", irq_n, 1);
        rd(3'd1, 8'h00, "lvl_pending_gone");

        // Edge source 2: single-cycle pulse latches, W1C clears.
        wr(3'd3, 8'h04);
        wr(3'd2, 8'h04);
        src_n = 8'hFB;
        tick();
        src_n = 8'hFF;
        ticks(2);
        check("edge_irq_k2", irq_n, 1);
        tick();
        check("edge_irq_k3", irq_n, 0);
        ticks(4);
        check("edge_irq_sticky", irq_n, 0);
        rd(3'd1, 8'h04, "edge_pending");
        wr(3'd1, 8'h04);
        check("edge_clr_e0", irq_n, 0);
        tick();
        check("edge_clr_e1", irq_n, 1);
        rd(3'd1, 8'h00, "edge_cleared");

        // Edge source 2: new fall on the same edge as its W1C -> set wins.
        src_n = 8'hFB;
        tick();
        src_n = 8'hFF;
        ticks(5);
        src_n = 8'hFB;
        tick();
        src_n = 8'hFF;
        tick();
        wr(3'd1, 8'h04);
        ticks(2);
        rd(3'd1, 8'h04, "setwins_pending");
        check("setwins_irq", irq_n, 0);
        wr(3'd1, 8'h04);
        rd(3'd1, 8'h00, "setwins_cleared");

        // Vector priority with sources 1 and 3, then masking.
        wr(3'd3, 8'h0A);
        wr(3'd2, 8'h0A);
        src_n = 8'hF5;
        tick();
        src_n = 8'hFF;
        ticks(4);
        rd(3'd4, 8'h01, "vec_both");
        wr(3'd1, 8'h02);
        rd(3'd4, 8'h03, "vec_src3");
        check("vec_irq", irq_n, 0);
        wr(3'd2, 8'h00);
        tick();
        check("mask_irq", irq_n, 1);
        rd(3'd1, 8'h08, "mask_pending_kept");
        rd(3'd4, 8'h80, "mask_vector_none");

        // Edge-to-level switch: idle line drops the sticky bit.
        wr(3'd3, 8'h00);
        tick();
        rd(3'd1, 8'h00, "mode_to_level");

        // NMI routing of source 4.
`ifdef IRQ_CTRL_NMI_EN
        wr(3'd5, 8'h10);
        src_n = 8'hEF;
        ticks(4);
        check("nmi_n_low", nmi_n, 0);
        check("nmi_irq_high", irq_n, 1);
        rd(3'd5, 8'h10, "nmi_sel");
        rd(3'd4, 8'h80, "nmi_vector");
`else
        wr(3'd5, 8'hFF);
        rd(3'd5, 8'h00, "nmi_sel_absent");
        src_n = 8'hEF;
        ticks(4);
        check("nmi_n_const", nmi_n, 1);
        check("nmi_irq_high", irq_n, 1);
`endif
        rd(3'd1, 8'h10, "nmi_pending");

        // Simultaneous read and write returns the pre-write value.
        wr_en    = 1'b1;
        rd_en    = 1'b1;
        reg_addr = 3'd2;
        wdata    = 8'h10;
        sb.push_back(8'h00);
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("rw_valid", rdata_valid, 1);
        check("rw_preval", rdata, sb.pop_front());
        tick();
        check("rw_irq_low", irq_n, 0);
        rd(3'd2, 8'h10, "rw_postval");

        // Writes to read-only registers are ignored.
        wr(3'd4, 8'h55);
        rd(3'd4, 8'h04, "ro_vector");

        // Mid-operation reset discards state without pulling irq_n low.
        src_n = 8'hFF;
        reset = 1'b1;
        tick();
        check("mid_rst_irq", irq_n, 1);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_irq", irq_n, 1);
        end
        rd(3'd1, 8'h00, "post_rst_pending");
        rd(3'd2, 8'h00, "post_rst_mask");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller directly upstream of the 6502 IRQB pin.
- Collects the active-low device interrupt lines (VIA1, VIA2, UART and its channel IRQs) and synchronises them to the system clock.
- Latches each source as level- or edge-triggered, masks it, and drives a registered, active-low irq_n.
- Exposes status, pending, mask, mode and vector registers in the BIFRÖST register window. Bus glue converts CPU cycles into single-cycle read/write strobes.

Parameters:
- SOURCES, 8, number of interrupt inputs (1..8); register bits at and above SOURCES read 0 and ignore writes.
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser (>=2).

Ports:
- clock  input  1  system clock (the divided CPU clock).
- reset  input  1  synchronous, active-high reset.
- src_n  input  SOURCES  raw device interrupt lines, active-low, asynchronous.
- wr_en  input  1  single-cycle register write strobe.
- rd_en  input  1  single-cycle register read strobe.
- reg_addr  input  3  register index.
- wdata  input  8  write data.
- rdata  output  8  registered read data.
- rdata_valid  output  1  high for exactly one cycle, the cycle after rd_en.
- irq_n  output  1  registered interrupt request to the CPU, active-low.
- nmi_n  output  1  registered NMI request, active-low (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high; takes effect on the clock edge where reset is high):
  - synchroniser and edge-history flops = 1; pending = 0x00; mask = 0x00; mode = 0x00;
  - irq_n = 1; nmi_n = 1; rdata = 0x00; rdata_valid = 0.
  - Reset asserted mid-operation discards all pending state. No irq_n glitch low.
- Synchronised level s[i] = output of the last synchroniser stage; asserted when 0.
- Edge detect: fall[i] = prev[i] & ~s[i]; prev[i] <= s[i] every cycle.
- Pending update, per source, every cycle:
  - mode[i]=0 (level): pending[i] <= ~s[i]. Write-1-to-clear has no effect while the line is held low.
  - mode[i]=1 (edge): pending[i] <= fall[i] | (pending[i] & ~clr[i]), where clr = wdata on a write to PENDING. Set and clear in the same cycle: set wins.
- irq_n <= ~|(pending & mask), registered.
- Latency with SYNC_STAGES=2:
  - src_n falls before edge k → s low after edge k+1 → pending set at k+2 → irq_n low after k+3.
  - Deassertion of a level source follows the same 4-edge path.
- Register map (reg_addr); unlisted addresses read 0x00 and ignore writes:
  - 0 STATUS (RO): ~s, i.e. 1 = line currently asserted.
  - 1 PENDING (R/W1C): latched requests. W1C applies to edge-mode bits only.
  - 2 MASK (RW): 1 = source enabled to irq_n. Masked sources still latch pending.
  - 3 MODE (RW): 1 = edge. Changing a bit from edge to level causes the level rule to apply from the next cycle.
  - 4 VECTOR (RO): {1'b0, 4'b0, idx[2:0]} of the lowest-numbered set bit of pending & mask; 0x80 when none. Evaluated on the current registered state.
  - 5 NMI_SEL: see Optional Feature.
- Read: on rd_en, rdata <= register value at that edge; rdata_valid <= 1 for one cycle. rdata holds its value until the next read.
- Simultaneous wr_en and rd_en: the write takes effect; the read returns the pre-write value.
- Writes to RO registers are ignored.

Optional Feature:
- Macro IRQ_CTRL_NMI_EN.
- When defined:
  - Register 5 NMI_SEL (RW, reset 0x00) routes sources to nmi_n.
  - nmi_n <= ~|(pending & NMI_SEL), registered; independent of MASK.
  - Sources selected for NMI still appear in VECTOR only if their MASK bit is set.
- When undefined: nmi_n is constant 1; register 5 reads 0x00 and ignores writes.

Test Plan:
- Reset with all src_n=1 → irq_n=1, nmi_n=1; reads of regs 0–4 return 0x00,0x00,0x00,0x00,0x80; rdata_valid pulses one cycle after each rd_en.
- MASK=0x01, MODE=0x00, drive src_n[0] low at edge 10 → irq_n low after edge 13; VECTOR=0x00; W1C 0x01 to PENDING while low → PENDING still 0x01; release src_n[0] → irq_n high 4 edges later.
- MODE=0x04, MASK=0x04, 1-cycle low pulse on src_n[2] → PENDING=0x04 and irq_n=0 persisting after the line returns high; write PENDING=0x04 → irq_n=1 two edges later.
- Edge source: a new falling edge arriving on the same cycle as its W1C write → pending stays 1.
- MASK=0x0A with sources 1 and 3 pending → VECTOR=0x01; clear source 1 → VECTOR=0x03; MASK=0x00 → irq_n=1, PENDING unchanged.
- IRQ_CTRL_NMI_EN: NMI_SEL=0x10, MASK=0x00, assert src_n[4] → nmi_n=0, irq_n=1; without the macro, nmi_n=1 and reg 5 reads 0x00 after writing 0xFF.
